sum_window_avg: RTL and testbench
=================================

// Module: sum_window_avg
// PURPOSE
//   Downstream consumer of the registered multi-operand adder stage. Takes its two
//   5-bit sum outputs (sum1 = a+b+c[+d] path, sum2 = a+b+c path) and accumulates
//   2**LOG2N valid samples of each into a window. Emits the window totals and
//   window averages through a valid/ready output handshake.
// PARAMETERS
//   IN_W   5  width of each incoming sum
//   LOG2N  2  log2 of samples per window (N = 4 by default); range 1..4
//   ACC_W  IN_W+LOG2N  accumulator/total width (derived localparam, not overridable)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_b    in   1      synchronous reset, active-low
//   clear      in   1      synchronous window flush, active-high
//   in_valid   in   1      sum1/sum2 hold a new sample
//   in_ready   out  1      block accepts a sample this cycle
//   sum1       in   IN_W   first adder result
//   sum2       in   IN_W   second adder result
//   out_valid  out  1      window result held on outputs
//   out_ready  in   1      consumer takes the result
//   tot1       out  ACC_W  window total of sum1
//   tot2       out  ACC_W  window total of sum2
//   avg1       out  IN_W   window average of sum1
//   avg2       out  IN_W   window average of sum2
//   cnt        out  LOG2N  samples accumulated in the current window
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (reset_b sampled on posedge clk).
//   - Reset: state=ACCUM, acc1=acc2=0, cnt=0, out_valid=0, tot*/avg*=0.
//   - FSM states:
//     * ACCUM: in_ready=1. On in_valid: acc+=sum, cnt+=1.
//       The sample with cnt==N-1 loads tot*/avg* from the final sums, zeroes acc/cnt,
//       and moves to HOLD. out_valid goes to 1 the cycle after that sample.
//     * HOLD: out_valid=1; tot*/avg* stable.
//       in_ready = out_ready (combinational), so a new sample can enter in the same
//       cycle the result leaves.
//       On out_ready: out_valid drops next cycle and the FSM returns to ACCUM.
//       A sample accepted in that same cycle counts as sample 0 of the next window.
//   - Transfer rules: input transfer = in_valid & in_ready; output transfer =
//     out_valid & out_ready. Data is never lost or duplicated under back-pressure.
//   - Arithmetic:
//     * all unsigned;
//     * acc is ACC_W bits and cannot overflow (N*(2**IN_W-1) fits);
//     * avg = acc >> LOG2N, truncating, unless ACC_ROUND_EN is defined.
//   - clear:
//     * zeroes acc/cnt next cycle;
//     * in ACCUM, a partial window is discarded;
//     * in HOLD, the held result stays valid;
//     * clear has priority over a same-cycle input transfer (that sample is dropped).
//   - reset_b low mid-window or in HOLD: everything returns to reset values next
//     edge; a pending result is lost.
//   - cnt wraps N-1 -> 0 only via window completion.
// CONFIGURATION
//   ACC_ROUND_EN
//     * defined: avg = (acc + 2**(LOG2N-1)) >> LOG2N, round half up.
//       No overflow: result is at most 2**IN_W-1.
//     * undefined: truncating shift.
//     * tot* is unaffected either way.
// STRUCTURE
//   - Package sum_window_pkg:
//     * state enum {ACCUM, HOLD};
//     * default IN_W/LOG2N constants;
//     * function for the ACC_W width calculation.
//   - One sub-module, sum_window_lane: a single accumulator lane
//     (acc register, completion add, average shift/round).
//   - Two lane instances share the FSM and cnt in the top.
// TESTING
//   1. N=4, out_ready=1, sum1=3,5,7,9 and sum2=1,1,1,1 on consecutive cycles
//      -> tot1=24, avg1=6, tot2=4, avg2=1; out_valid high 1 cycle.
//   2. Rounding: sum1=1,2,2,2 (tot1=7)
//      -> avg1=1 without ACC_ROUND_EN, avg1=2 with it.
//   3. Max value: sum1=sum2=31 for 4 samples -> tot=124, avg=31 in both configs.
//   4. Back-pressure: out_ready=0 for 5 cycles after a window with in_valid held 1
//      -> in_ready=0, outputs stable. Then out_ready=1 for one cycle
//      -> that sample becomes cnt=1 of the next window.
//   5. clear asserted with in_valid at cnt=2 -> sample dropped, cnt=0.
//      Next 4 samples of 4 -> tot1=16.
//   6. reset_b=0 for 1 cycle while in HOLD -> out_valid=0, cnt=0, tot/avg=0
//      next cycle; a full new window completes normally.

Source files
------------

// File: rtl/sum_window_pkg.sv
// sum_window_pkg: shared state encoding, default sizes and accumulator width helper
package sum_window_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int DEF_IN_W  = 5;
    localparam int DEF_LOG2N = 2;

    // Accumulator must hold N full-scale samples without overflow.
    function automatic int acc_width(input int in_w, input int log2n);
        return in_w + log2n;
    endfunction

endpackage

// File: rtl/sum_window_lane.sv
// sum_window_lane: one accumulator lane (running sum, window total, window average)
// Ports: clk, reset_b (sync, active-low), clear (flush acc), take (sample accepted),
//        last (accepted sample closes the window), sum (incoming sample),
//        tot (window total), avg (window average).
// ACC_ROUND_EN defined: average rounds half up; otherwise it truncates.
module sum_window_lane import sum_window_pkg::*; #(
    parameter  int IN_W  = DEF_IN_W,
    parameter  int LOG2N = DEF_LOG2N,
    localparam int ACC_W = acc_width(IN_W, LOG2N)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clear,
    input  logic             take,
    input  logic             last,
    input  logic [IN_W-1:0]  sum,
    output logic [ACC_W-1:0] tot,
    output logic [IN_W-1:0]  avg
);

    logic [ACC_W-1:0] acc, fin, rnd;

    // Total including the sample arriving this cycle, so the final sample lands directly in tot.
    assign fin = acc + {{LOG2N{1'b0}}, sum};

`ifdef ACC_ROUND_EN
    // Cannot overflow: N*(2**IN_W-1) + N/2 < N*2**IN_W.
    assign rnd = fin + ACC_W'(1 << (LOG2N - 1));
`else
    assign rnd = fin;
`endif

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            acc <= '0;
            tot <= '0;
            avg <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (take) begin
            acc <= last ? '0 : fin;
            if (last) begin
                tot <= fin;
                avg <= rnd[ACC_W-1:LOG2N];
            end
        end
    end

endmodule

// File: rtl/sum_window_avg.sv
// sum_window_avg: windows 2**LOG2N samples of two sums and emits totals/averages via valid/ready
// Ports: clk, reset_b (sync, active-low), clear (sync window flush),
//        in_valid/in_ready + sum1/sum2 (sample input), out_valid/out_ready (result handshake),
//        tot1/tot2 (window totals), avg1/avg2 (window averages), cnt (samples in current window).
// ACC_ROUND_EN defined: averages round half up; otherwise they truncate.
module sum_window_avg import sum_window_pkg::*; #(
    parameter  int IN_W  = DEF_IN_W,
    parameter  int LOG2N = DEF_LOG2N,
    localparam int ACC_W = acc_width(IN_W, LOG2N)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  sum1,
    input  logic [IN_W-1:0]  sum2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] tot1,
    output logic [ACC_W-1:0] tot2,
    output logic [IN_W-1:0]  avg1,
    output logic [IN_W-1:0]  avg2,
    output logic [LOG2N-1:0] cnt
);

    state_t state, state_nx;
    logic   take, last;

    // clear wins over a simultaneous sample, which is then dropped.
    assign take = in_valid & in_ready & ~clear;
    assign last = take & (cnt == {LOG2N{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= ACCUM;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (clear)
                cnt <= '0;
            else if (take)
                cnt <= cnt + 1'b1;
        end
    end

    // A sample taken while the result leaves HOLD starts the next window (cnt is 0 there).
    always_comb begin
        state_nx = state;
        if (state == ACCUM)
            state_nx = last ? HOLD : ACCUM;
        else
            state_nx = out_ready ? ACCUM : HOLD;
    end

    always_comb begin
        out_valid = state == HOLD;
        in_ready  = (state == ACCUM) ? 1'b1 : out_ready;
    end

    sum_window_lane #(.IN_W(IN_W), .LOG2N(LOG2N)) lane1 (
        .clk(clk), .reset_b(reset_b), .clear(clear), .take(take), .last(last),
        .sum(sum1), .tot(tot1), .avg(avg1)
    );

    sum_window_lane #(.IN_W(IN_W), .LOG2N(LOG2N)) lane2 (
        .clk(clk), .reset_b(reset_b), .clear(clear), .take(take), .last(last),
        .sum(sum2), .tot(tot2), .avg(avg2)
    );

endmodule

// File: tb/tb_sum_window_avg.sv
// tb_sum_window_avg: directed self-checking bench for sum_window_avg (N=4)
module tb_sum_window_avg;

    logic       clk = 0, reset_b = 0, clear = 0, in_valid = 0, out_ready = 1;
    logic [4:0] sum1 = 0, sum2 = 0;
    logic       in_ready, out_valid;
    logic [6:0] tot1, tot2;
    logic [4:0] avg1, avg2;
    logic [1:0] cnt;
    int         total = 0, bad = 0;

    sum_window_avg dut (
        .clk(clk), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .sum1(sum1), .sum2(sum2), .out_valid(out_valid), .out_ready(out_ready),
        .tot1(tot1), .tot2(tot2), .avg1(avg1), .avg2(avg2), .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s1, input int s2);
        in_valid = 1;
        sum1 = 5'(s1);
        sum2 = 5'(s2);
        step();
        in_valid = 0;
    endtask

    task automatic result(input string tag, input int t1, input int a1, input int t2, input int a2);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_tot1"}, tot1, t1);
        chk({tag, "_avg1"}, avg1, a1);
        chk({tag, "_tot2"}, tot2, t2);
        chk({tag, "_avg2"}, avg2, a2);
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_tot1", tot1, 0);
        chk("rst_avg2", avg2, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_b = 1;

        // basic window
        send(3, 1); send(5, 1);
        chk("t1_cnt2", cnt, 2);
        send(7, 1); send(9, 1);
        result("t1", 24, 6, 4, 1);
        chk("t1_cnt_wrap", cnt, 0);
        step();
        chk("t1_valid_drop", out_valid, 0);

        // rounding
        send(1, 0); send(2, 0); send(2, 0); send(2, 0);
`ifdef ACC_ROUND_EN
        result("t2", 7, 2, 0, 0);
`else
        result("t2", 7, 1, 0, 0);
`endif
        step();

        // full scale
        for (int i = 0; i < 4; i++) send(31, 31);
        result("t3", 124, 31, 124, 31);
        step();

        // back-pressure
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(4, 2);
        in_valid = 1;
        sum1 = 10;
        sum2 = 2;
        for (int i = 0; i < 5; i++) begin
            chk("t4_in_ready", in_ready, 0);
            result("t4_hold", 16, 4, 8, 2);
            chk("t4_cnt", cnt, 0);
            step();
        end
        out_ready = 1;
        #1;
        chk("t4_in_ready_pass", in_ready, 1);
        step();
        chk("t4_valid_drop", out_valid, 0);
        chk("t4_cnt_carry", cnt, 1);
        send(1, 1); send(1, 1); send(1, 1);
        result("t4_next", 13, 3, 5, 1);
        step();

        // clear drops a partial window and the same-cycle sample
        send(7, 7); send(7, 7);
        chk("t5_cnt2", cnt, 2);
        clear = 1;
        send(9, 9);
        clear = 0;
        chk("t5_cnt_clr", cnt, 0);
        chk("t5_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) send(4, 0);
        result("t5", 16, 4, 0, 0);
        step();

        // reset while holding a result
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(5, 5);
        chk("t6_hold", out_valid, 1);
        reset_b = 0;
        step();
        reset_b = 1;
        chk("t6_valid", out_valid, 0);
        chk("t6_cnt", cnt, 0);
        chk("t6_tot1", tot1, 0);
        chk("t6_avg1", avg1, 0);
        chk("t6_tot2", tot2, 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) send(8, 3);
        result("t6_new", 32, 8, 12, 3);
        step();
        chk("t6_end_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
